// File: rtl/seg_disp_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
// Priority encoding works on a fixed-width vector; callers zero-extend their request vectors.
package seg_disp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_RST = 4'h0;

  localparam int MAX_REQ = 32;

  typedef struct packed {
    logic       vld;
    logic [4:0] idx;
  } prio_t;

  // Lowest set index wins; vld is clear when the vector is all-zero.
  function automatic prio_t prio_enc(input logic [MAX_REQ-1:0] vec);
    prio_t r;
    r.vld = 1'b0;
    r.idx = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.vld = 1'b1;
        r.idx = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Enable-gated modulo-DIV counter producing a one-cycle pulse on its last count.
// The pulse is a decode of the registered count, so it is high while en_i is high and the count is DIV-1.
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner of the quad seven-segment display with a minimum hold before preemption.
// Grant, digits and blank update together one cycle after the request/data change.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = 50000000,
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]    blink_en,
  output logic [NUM_REQ-1:0]    grant,
  output logic [DIGIT_W-1:0]    num0,
  output logic [DIGIT_W-1:0]    num1,
  output logic [DIGIT_W-1:0]    num2,
  output logic [DIGIT_W-1:0]    num3,
  output logic                  blank,
  output logic                  scan_tick,
  output logic                  busy
);

  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam int NW = DIGIT_W * DIGITS;

  state_e              state_q, state_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NW-1:0]       num_q, num_d;
  logic                blank_q, blank_d;
  logic                busy_q;
  logic                blink_phase_q;
  logic                blink_wrap;
  logic                scan_tick_w;

  logic [MAX_REQ-1:0]  req_ext;
  prio_t               pe;
  logic [IW-1:0]       pe_idx;
  logic [NW-1:0]       slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice[g] = req_data[16*g +: 16];
  end

  assign req_ext = MAX_REQ'(req);
  assign pe      = prio_enc(req_ext);
  assign pe_idx  = pe.idx[IW-1:0];

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (1'b1),
    .tick_o (scan_tick_w)
  );

  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (scan_tick_w),
    .tick_o (blink_wrap)
  );

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pe.vld) begin
          state_d = OWNED;
          gidx_d  = pe_idx;
          hold_d  = '0;
        end
      end
      OWNED: begin
        // A dropped owner releases at once; the hold only shields a live owner.
        if (!req[gidx_q]) begin
          hold_d = '0;
          if (pe.vld) begin
            gidx_d = pe_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q == HOLD_MAX && pe_idx < gidx_q) begin
          gidx_d = pe_idx;
          hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Digits and blank follow the next owner so they never lag the grant.
  always_comb begin
    grant_d = '0;
    num_d   = num_q;
    blank_d = 1'b1;
    if (state_d == OWNED) begin
      grant_d[gidx_d] = 1'b1;
      num_d           = slice[gidx_d];
      blank_d         = blink_en[gidx_d] & ~blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gidx_q        <= '0;
      hold_q        <= '0;
      grant_q       <= '0;
      num_q         <= {DIGITS{DIGIT_RST}};
      blank_q       <= 1'b1;
      busy_q        <= 1'b0;
      blink_phase_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      gidx_q        <= gidx_d;
      hold_q        <= hold_d;
      grant_q       <= grant_d;
      num_q         <= num_d;
      blank_q       <= blank_d;
      busy_q        <= (state_d == OWNED);
      blink_phase_q <= blink_wrap ? ~blink_phase_q : blink_phase_q;
    end
  end

  assign grant     = grant_q;
  assign num0      = num_q[0*DIGIT_W +: DIGIT_W];
  assign num1      = num_q[1*DIGIT_W +: DIGIT_W];
  assign num2      = num_q[2*DIGIT_W +: DIGIT_W];
  assign num3      = num_q[3*DIGIT_W +: DIGIT_W];
  assign blank     = blank_q;
  assign scan_tick = scan_tick_w;
  assign busy      = busy_q;

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the 4-digit seven-segment display between NUM_REQ requesters (score, timer, status message, ...) using fixed priority with a minimum-hold guarantee. It drives the num0..num3 digit inputs of the quad display driver. It also supplies the driver's scan-rate enable tick and per-requester blink gating. It sits between the game/control logic and the display driver.

Parameters:
NUM_REQ, 3, number of requesters; index 0 has the highest priority.
HOLD_CYCLES, 50000000, minimum clk cycles a grant is held before a higher-priority requester can preempt it; 0 means immediate preemption.
SCAN_DIV, 100000, clk cycles per scan_tick pulse; must be >= 2.
BLINK_DIV, 250, scan_ticks per blink half-period; must be >= 1.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-low reset.
req  in  NUM_REQ  request level per requester; held high while the requester wants the display.
req_data  in  16*NUM_REQ  4 hex digits per requester; slice i is bits [16i+15:16i]; nibble 0 is the rightmost digit.
blink_en  in  NUM_REQ  blink the display while requester i is granted.
grant  out  NUM_REQ  one-hot or all-zero, registered.
num0  out  4  rightmost digit value.
num1  out  4  second digit from the right.
num2  out  4  second digit from the left.
num3  out  4  leftmost digit value.
blank  out  1  1 = all digits off; the top level gates the anodes with this.
scan_tick  out  1  one-cycle pulse every SCAN_DIV clk cycles; the enable for the digit scanner.
busy  out  1  1 while any grant is active.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - outputs: grant=0, num0..3=0, blank=1, scan_tick=0, busy=0.
  - internal: hold counter=0, scan counter=0, blink counter=0, blink_phase=1 (visible), state=IDLE.
  - Reset mid-grant takes effect at the next edge regardless of req.
- scan_tick counter:
  - Free-running 0..SCAN_DIV-1.
  - scan_tick=1 in the cycle the counter equals SCAN_DIV-1; the counter then wraps to 0.
  - Not affected by arbitration.
- blink:
  - The blink counter advances on scan_tick and wraps at BLINK_DIV-1.
  - blink_phase toggles on each wrap.
- State machine, states IDLE and OWNED:
  - IDLE, no req: stays IDLE; grant=0, blank=1, num held at their last values.
  - IDLE, any req sampled high: next edge -> OWNED. grant is one-hot on the lowest active index, hold counter=0, busy=1.
  - OWNED, granted req still high and hold counter < HOLD_CYCLES: hold counter increments (saturates at HOLD_CYCLES); no preemption.
  - OWNED, hold counter == HOLD_CYCLES and a lower-index req is high: next edge grant moves to the lowest active index; hold counter=0.
  - OWNED, granted req drops: next edge grant moves to the lowest remaining active req with hold counter=0, or -> IDLE if none. A drop releases immediately; the hold does not apply.
  - Simultaneous drop and new higher-priority req: the winner is the lowest active index at that edge.
- Data path:
  - num0..3 are registered every cycle from the req_data slice of the requester selected for the next grant. The same edge updates grant and num, so num is never from a non-granted source.
  - Latency: req or data change -> output is 1 cycle.
- blank = 1 when grant==0, OR when blink_en[granted] && blink_phase==0. Registered; same 1-cycle latency.
- Width rules:
  - hold counter width = clog2(HOLD_CYCLES+1).
  - scan counter width = clog2(SCAN_DIV).
  - blink counter width = clog2(BLINK_DIV) (minimum 1).
  - Counters wrap or saturate only as stated; no overflow.
- HOLD_CYCLES=0: preemption is possible on the cycle after the grant.

Decomposition:
- Package seg_disp_pkg holds:
  - the state enum {IDLE, OWNED};
  - DIGIT_W=4 and DIGITS=4;
  - the reset digit value 4'h0.
- A priority-encode function (lowest set index, plus a valid flag) also goes in the package.
- One natural sub-module: tick_divider (parameter DIV; outputs a one-cycle pulse; synchronous active-low reset). Instantiate it twice: once for scan_tick (DIV=SCAN_DIV) and once, enabled by scan_tick, for the blink wrap (DIV=BLINK_DIV).

Test Plan:
Use NUM_REQ=3, HOLD_CYCLES=8, SCAN_DIV=4, BLINK_DIV=2 unless stated.
1. Reset then idle: rst_n low 3 cycles -> grant=000, blank=1, num all 0, scan_tick pulses every 4th cycle after release (cycles 4, 8, 12, ...).
2. req=100, req_data[2]=16'h1234 -> 1 cycle later grant=100, num3..0=1,2,3,4, blank=0, busy=1. Changing data to 16'h5678 shows 5,6,7,8 one cycle later.
3. Requester 2 owns the display; raise req[0] at hold count 3 (req_data[0]=16'hABCD) -> grant stays 100 until hold count reaches 8, then grant=001 and num=A,B,C,D on the next edge.
4. Requester 0 owns the display and req[1] is high; drop req[0] at hold count 2 -> next edge grant=010; dropping req[1] afterwards -> grant=000, blank=1, busy=0.
5. Granted requester has blink_en=1 -> blank toggles every 8 clk cycles (2 scan_ticks). blink_en=0 -> blank stays 0.
6. rst_n pulsed low for 1 cycle while grant=001 -> next edge all outputs are at reset values; with req still high, the grant returns 1 cycle after rst_n rises.
